// File: rtl/add16_rr_share_ctrl.sv
// Round-robin share of one external approximate adder, with an exact-sum bypass and saturating usage counters.
// Result registered one cycle after acceptance; a held response (rsp_ready=0) blocks all grants.
module add16_rr_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2,
  parameter int CW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_exact,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_exact,
  output logic [CW-1:0]     approx_cnt,
  output logic [CW-1:0]     exact_cnt
);

  logic           r_rsp_valid;
  logic [W:0]     r_rsp_sum;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_exact;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_approx_cnt;
  logic [CW-1:0]  r_exact_cnt;

  logic           w_slot_free;
  logic           w_any;
  logic           w_gnt;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_ptr_nxt;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_exact;
  logic [W:0]     w_exact_sum;
  logic [W:0]     w_sum;
  int             w_scan;

  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_any && req_valid[w_scan]) begin
        w_any     = 1'b1;
        w_gnt_idx = IDW'(w_scan);
      end
    end
  end

  assign w_gnt       = w_slot_free && w_any;
  assign w_a         = req_a[w_gnt_idx*W +: W];
  assign w_b         = req_b[w_gnt_idx*W +: W];
  assign w_exact     = req_exact[w_gnt_idx];
  assign w_exact_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum       = w_exact ? w_exact_sum : add_o;
  assign w_ptr_nxt   = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  assign req_ready = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;

  // Operands are zeroed unless the shared adder is actually used, to keep it quiet.
  assign add_a = (w_gnt && !w_exact) ? w_a : '0;
  assign add_b = (w_gnt && !w_exact) ? w_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_sum    <= '0;
      r_rsp_id     <= '0;
      r_rsp_exact  <= 1'b0;
      r_rr_ptr     <= '0;
      r_approx_cnt <= '0;
      r_exact_cnt  <= '0;
    end else if (w_gnt) begin
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_exact <= w_exact;
      r_rr_ptr    <= w_ptr_nxt;
      if (w_exact) begin
        if (r_exact_cnt != '1) r_exact_cnt <= r_exact_cnt + 1'b1;
      end else begin
        if (r_approx_cnt != '1) r_approx_cnt <= r_approx_cnt + 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_id     = r_rsp_id;
  assign rsp_exact  = r_rsp_exact;
  assign approx_cnt = r_approx_cnt;
  assign exact_cnt  = r_exact_cnt;

endmodule

// File: tb/tb_add16_rr_share_ctrl.sv
// Directed vector table plus hand sequences for reset-mid-transaction and counter saturation.
module tb_add16_rr_share_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_exact;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [16:0] add_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [16:0] rsp_sum;
  logic [1:0]  rsp_id;
  logic        rsp_exact;
  logic [31:0] approx_cnt;
  logic [31:0] exact_cnt;

  logic        fen;
  logic [16:0] fval;

  logic [3:0]  s_req_ready;
  logic [15:0] s_add_a;
  logic [15:0] s_add_b;
  logic [16:0] s_add_o;
  logic        s_rsp_valid;
  logic [16:0] s_rsp_sum;
  logic [1:0]  s_rsp_id;
  logic        s_rsp_exact;
  logic [3:0]  s_approx_cnt;
  logic [3:0]  s_exact_cnt;

  int n_vec;
  int n_cmp;
  int n_err;

  // Adder model: exact add unless the bench forces a value.
  assign add_o   = fen ? fval : ({1'b0, add_a} + {1'b0, add_b});
  assign s_add_o = {1'b0, s_add_a} + {1'b0, s_add_b};

  add16_rr_share_ctrl #(.NREQ(4), .W(16), .IDW(2), .CW(32)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_exact(req_exact),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_exact(rsp_exact),
    .approx_cnt(approx_cnt), .exact_cnt(exact_cnt)
  );

  add16_rr_share_ctrl #(.NREQ(4), .W(16), .IDW(2), .CW(4)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_a(req_a), .req_b(req_b), .req_exact(req_exact),
    .add_a(s_add_a), .add_b(s_add_b), .add_o(s_add_o),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(s_rsp_sum),
    .rsp_id(s_rsp_id), .rsp_exact(s_rsp_exact),
    .approx_cnt(s_approx_cnt), .exact_cnt(s_exact_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  ex;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;
    logic        fen;
    logic [16:0] fval;
    logic [3:0]  e_rr;
    logic [15:0] e_aa;
    logic [15:0] e_ab;
    logic        e_rv;
    logic [16:0] e_sum;
    logic [1:0]  e_id;
    logic        e_ex;
    int          e_ac;
    int          e_ec;
  } vec_t;

  localparam logic [63:0] OPA = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] OPB = {16'd400, 16'd300, 16'd200, 16'd100};
  localparam logic [63:0] A1  = 64'd100;
  localparam logic [63:0] B1  = 64'd23;
  localparam logic [63:0] AF  = {16'h0000, 16'hFFFF, 32'h0};
  localparam logic [63:0] BF  = {16'h0000, 16'h0001, 32'h0};

  vec_t tbl[17];

  function automatic vec_t mkv(
    input logic r, input logic [3:0] v, input logic [3:0] e,
    input logic [63:0] a, input logic [63:0] b, input logic rd,
    input logic fe, input logic [16:0] fv,
    input logic [3:0] err, input logic [15:0] eaa, input logic [15:0] eab,
    input logic erv, input logic [16:0] esum, input logic [1:0] eid,
    input logic eex, input int eac, input int eec);
    vec_t t;
    t.rst = r;  t.vld = v;  t.ex = e;  t.a = a;  t.b = b;  t.rdy = rd;
    t.fen = fe; t.fval = fv;
    t.e_rr = err; t.e_aa = eaa; t.e_ab = eab; t.e_rv = erv; t.e_sum = esum;
    t.e_id = eid; t.e_ex = eex; t.e_ac = eac; t.e_ec = eec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] e,
                       input logic [63:0] a, input logic [63:0] b, input logic rd);
    rst = r; req_valid = v; req_exact = e; req_a = a; req_b = b; rsp_ready = rd;
  endtask

  task automatic apply(input vec_t t);
    drive(t.rst, t.vld, t.ex, t.a, t.b, t.rdy);
    fen  = t.fen;
    fval = t.fval;
    #1;
    chk("req_ready", 32'(req_ready), 32'(t.e_rr));
    chk("add_a", 32'(add_a), 32'(t.e_aa));
    chk("add_b", 32'(add_b), 32'(t.e_ab));
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'(t.e_rv));
    chk("rsp_sum", 32'(rsp_sum), 32'(t.e_sum));
    chk("rsp_id", 32'(rsp_id), 32'(t.e_id));
    chk("rsp_exact", 32'(rsp_exact), 32'(t.e_ex));
    chk("approx_cnt", approx_cnt, 32'(t.e_ac));
    chk("exact_cnt", exact_cnt, 32'(t.e_ec));
    n_vec++;
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_err = 0;
    fen = 1'b0; fval = '0;
    drive(1'b1, 4'b0, 4'b0, 64'd0, 64'd0, 1'b0);

    //            rst vld     ex      a    b    rdy fen fval      rr      aa         ab         rv sum         id ex ac ec
    tbl[0]  = mkv(1, 4'b0000, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     0, 17'd0,      0, 0, 0, 0);
    tbl[1]  = mkv(0, 4'b0001, 4'b0001, A1,  B1,  1, 0, 17'd0,   4'b0001, 16'd0,     16'd0,     1, 17'd123,    0, 1, 0, 1);
    tbl[2]  = mkv(1, 4'b0000, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     0, 17'd0,      0, 0, 0, 0);
    tbl[3]  = mkv(0, 4'b1111, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0001, 16'd1,     16'd100,   1, 17'd101,    0, 0, 1, 0);
    tbl[4]  = mkv(0, 4'b1111, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0010, 16'd2,     16'd200,   1, 17'd202,    1, 0, 2, 0);
    tbl[5]  = mkv(0, 4'b1111, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0100, 16'd3,     16'd300,   1, 17'd303,    2, 0, 3, 0);
    tbl[6]  = mkv(0, 4'b1111, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b1000, 16'd4,     16'd400,   1, 17'd404,    3, 0, 4, 0);
    tbl[7]  = mkv(0, 4'b1111, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0001, 16'd1,     16'd100,   1, 17'd101,    0, 0, 5, 0);
    tbl[8]  = mkv(0, 4'b0100, 4'b0000, AF,  BF,  1, 1, 17'h5,   4'b0100, 16'hFFFF,  16'h0001,  1, 17'h00005,  2, 0, 6, 0);
    tbl[9]  = mkv(0, 4'b0100, 4'b0100, AF,  BF,  1, 1, 17'h5,   4'b0100, 16'd0,     16'd0,     1, 17'h10000,  2, 1, 6, 1);
    tbl[10] = mkv(0, 4'b0000, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     0, 17'h10000,  2, 1, 6, 1);
    tbl[11] = mkv(0, 4'b0001, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0001, 16'd1,     16'd100,   1, 17'd101,    0, 0, 7, 1);
    tbl[12] = mkv(0, 4'b1010, 4'b0000, OPA, OPB, 0, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     1, 17'd101,    0, 0, 7, 1);
    tbl[13] = mkv(0, 4'b1010, 4'b0000, OPA, OPB, 0, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     1, 17'd101,    0, 0, 7, 1);
    tbl[14] = mkv(0, 4'b1010, 4'b0000, OPA, OPB, 0, 0, 17'd0,   4'b0000, 16'd0,     16'd0,     1, 17'd101,    0, 0, 7, 1);
    tbl[15] = mkv(0, 4'b1010, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b0010, 16'd2,     16'd200,   1, 17'd202,    1, 0, 8, 1);
    tbl[16] = mkv(0, 4'b1010, 4'b0000, OPA, OPB, 1, 0, 17'd0,   4'b1000, 16'd4,     16'd400,   1, 17'd404,    3, 0, 9, 1);

    tick();
    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // Reset while a response is pending; requester 2 leaves the pointer at 3.
    fen = 1'b0;
    drive(1'b1, 4'b0000, 4'b0000, OPA, OPB, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'b0100, 4'b0000, OPA, OPB, 1'b1);
      tick();
      n_vec++;
    end
    chk("pre_rst rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst approx_cnt", approx_cnt, 32'd7);
    chk("pre_rst rsp_sum", 32'(rsp_sum), 32'd303);
    drive(1'b1, 4'b1100, 4'b0000, OPA, OPB, 1'b0);
    #1;
    chk("rst bp req_ready", 32'(req_ready), 32'd0);
    tick();
    n_vec++;
    chk("post_rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst approx_cnt", approx_cnt, 32'd0);
    chk("post_rst rsp_sum", 32'(rsp_sum), 32'd0);
    chk("post_rst rsp_id", 32'(rsp_id), 32'd0);
    drive(1'b0, 4'b1100, 4'b0000, OPA, OPB, 1'b1);
    #1;
    chk("post_rst req_ready", 32'(req_ready), 32'b0100);
    chk("post_rst add_a", 32'(add_a), 32'd3);
    tick();
    n_vec++;
    chk("post_rst grant id", 32'(rsp_id), 32'd2);
    chk("post_rst grant sum", 32'(rsp_sum), 32'd303);
    chk("post_rst grant cnt", approx_cnt, 32'd1);

    // Saturation on the 4-bit counter instance.
    drive(1'b1, 4'b0000, 4'b0000, OPA, OPB, 1'b1);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 4'b0001, 4'b0000, OPA, OPB, 1'b1);
      tick();
      n_vec++;
      if (i == 14) chk("sat approx_cnt at 15", 32'(s_approx_cnt), 32'd15);
    end
    chk("sat approx_cnt held", 32'(s_approx_cnt), 32'd15);
    chk("sat exact_cnt", 32'(s_exact_cnt), 32'd0);
    chk("wide approx_cnt", approx_cnt, 32'd17);
    drive(1'b0, 4'b0001, 4'b0001, OPA, OPB, 1'b1);
    tick();
    n_vec++;
    chk("sat exact_cnt inc", 32'(s_exact_cnt), 32'd1);
    chk("sat approx_cnt after exact", 32'(s_approx_cnt), 32'd15);
    chk("sat exact rsp_sum", 32'(s_rsp_sum), 32'd101);

    drive(1'b0, 4'b0000, 4'b0000, OPA, OPB, 1'b1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
